feature_map_buffer_pingpong_1wnr: RTL and testbench
===================================================

Name: feature_map_buffer_pingpong_1wnr

Overview:
- Parametrised successor of the 1-write/3-read feature-map buffer.
- NUM_RD read ports, each served by replicated block RAM.
- Two banks form a ping-pong pair: the C1 producer fills one bank while P1..Pn consumers read the other.
- Bank ownership passes through a frame-level done handshake, so producer and consumers overlap without corrupting a frame.

Parameters:
- DATA_WIDTH, 8, signed feature element width.
- ADDR_WIDTH, 10, element address width per bank.
- RAM_DEPTH, 1<<ADDR_WIDTH, elements per bank.
- NUM_RD, 3, number of independent read ports (1..8).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_wr_en  in  1  write strobe.
- i_wr_addr  in  ADDR_WIDTH  write address within the current write bank.
- i_wr_data  in  DATA_WIDTH  signed write data.
- i_wr_last  in  1  qualifies i_wr_en; this write closes the frame.
- o_wr_ready  out  1  a bank is owned by the writer.
- i_rd_en  in  NUM_RD  per-port read strobe.
- i_rd_addr  in  NUM_RD*ADDR_WIDTH  per-port address; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- o_rd_data  out  NUM_RD*DATA_WIDTH  per-port registered data, packed the same way.
- o_rd_valid  out  NUM_RD  per-port data valid.
- i_rd_done  in  NUM_RD  per-port pulse: port has finished the current frame.
- o_rd_ready  out  1  a full bank is owned by the readers.
- o_err  out  1  sticky protocol-violation flag.

Behaviour:
- Per-bank state, 2 bits: EMPTY -> FILLING (first accepted write) -> FULL (accepted write with i_wr_last) -> EMPTY (release).
- A single-write frame goes EMPTY -> FULL directly.
- Pointers wr_bank and rd_bank are 1 bit each; both reset to 0.
- o_wr_ready = state[wr_bank] is EMPTY or FILLING.
- o_rd_ready = state[rd_bank] is FULL.
- Write accepted when i_wr_en && o_wr_ready. Data is written to all NUM_RD RAM copies of wr_bank.
- If the accepted write has i_wr_last: bank -> FULL, wr_bank toggles the same edge.
- i_wr_en while !o_wr_ready: write dropped, o_err set.
- Read on port k accepted when i_rd_en[k] && o_rd_ready. o_rd_data[k] = copy k of rd_bank at the address, registered.
- Read latency is 1 cycle. o_rd_valid[k] is high the cycle after an accepted read and low otherwise.
- o_rd_data[k] holds its last value when no read is accepted.
- i_rd_en[k] while !o_rd_ready: ignored, o_rd_valid[k] stays 0, o_err set.
- done_mask (NUM_RD bits) sets bit k on i_rd_done[k] while o_rd_ready. Repeated pulses are harmless.
- i_rd_done while !o_rd_ready sets o_err.
- When (done_mask | i_rd_done) is all ones: bank -> EMPTY, rd_bank toggles, done_mask clears, all on the same edge.
- Reads accepted in the releasing cycle still return data from the released bank. Its contents are untouched until it is rewritten.
- Simultaneous events:
  - Writer closes bank X while readers release bank Y: both take effect.
  - A bank released in cycle t is write-ready in cycle t+1.
  - A bank filled in cycle t is read-ready in cycle t+1. It is never visible the same cycle.
- Both banks FULL: o_wr_ready=0 (backpressure).
- Both banks EMPTY: o_rd_ready=0.
- No read-during-write hazard exists, because the writer and readers never own the same bank.
- Reset: all bank states EMPTY, pointers 0, done_mask 0, o_rd_valid 0, o_rd_data 0, o_err 0.
- RAM contents are not reset.
- Reset mid-frame discards partial and full frames.
- No arithmetic beyond the 1-bit pointer toggles; there is no width conversion of data.

Decomposition:
- Package fmb_pkg holds:
  - the bank-state localparams (EMPTY=2'd0, FILLING=2'd1, FULL=2'd2);
  - the MAX_NUM_RD=8 constant.
- Sub-module fmb_bank_1wnr: one bank of NUM_RD replicated block RAMs. It has one write port and NUM_RD registered read ports.
- The top level instantiates fmb_bank_1wnr twice and holds the bank FSMs, pointers, done_mask, read muxing and o_err.

Test Plan:
- Reset, then write addr 0..15 with data = addr-8, i_wr_last on addr 15 -> o_rd_ready=1 next cycle, o_wr_ready stays 1 (bank 1 free); ports 0/1/2 read addrs 15/0/7 -> one cycle later o_rd_data = 7/-8/-1, o_rd_valid=3'b111.
- Overlap: while readers hold bank 0, write frame 2 (data=addr+100) into bank 1; i_rd_done pulses on ports 0, 2, 1 in separate cycles -> bank 0 released only after the third pulse; next reads return addr+100.
- Backpressure: fill both banks without any i_rd_done -> o_wr_ready=0; further i_wr_en -> o_err=1, bank contents unchanged on readback.
- Simultaneous release and fill: final i_rd_done in the same cycle as i_wr_last -> next cycle o_rd_ready=1 pointing at the new bank, o_wr_ready=1 on the released bank.
- Idle read: i_rd_en=3'b101 with both banks EMPTY -> o_rd_valid=0, o_rd_data unchanged, o_err=1.
- Mid-frame reset: assert rst after 5 writes of a frame -> all outputs at reset values next cycle; a new full frame then reads back correctly.

Source files
------------

// File: rtl/fmb_pkg.sv
// Shared constants for the ping-pong feature-map buffer.
// Bank-state encodings and the read-port limit.
package fmb_pkg;

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] FILLING = 2'd1;
  localparam logic [1:0] FULL    = 2'd2;

  localparam int MAX_NUM_RD = 8;

endpackage

// File: rtl/fmb_bank_1wnr.sv
// One bank: NUM_RD replicated RAM copies, one shared write
// port, NUM_RD registered read ports (clk, rst, wr_*, rd_*).
module fmb_bank_1wnr
  import fmb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int NUM_RD     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data
);

  if (NUM_RD < 1 || NUM_RD > MAX_NUM_RD) begin : g_bad_num_rd
    $error("fmb_bank_1wnr: NUM_RD out of range");
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_copy
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [ADDR_WIDTH-1:0] ra;

    assign ra = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

    // Every copy sees every write so all ports read the same frame.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] <= '0;
      end else if (rd_en[k]) begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] <= mem[ra];
      end
    end
  end

endmodule

// File: rtl/feature_map_buffer_pingpong_1wnr.sv
// Ping-pong feature-map buffer, 1 writer / NUM_RD readers.
// Ports: clk, rst, i_wr_* / o_wr_ready, i_rd_* / o_rd_*, o_err.
module feature_map_buffer_pingpong_1wnr
  import fmb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int NUM_RD     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [ADDR_WIDTH-1:0]        i_wr_addr,
  input  logic [DATA_WIDTH-1:0]        i_wr_data,
  input  logic                         i_wr_last,
  output logic                         o_wr_ready,
  input  logic [NUM_RD-1:0]            i_rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] o_rd_data,
  output logic [NUM_RD-1:0]            o_rd_valid,
  input  logic [NUM_RD-1:0]            i_rd_done,
  output logic                         o_rd_ready,
  output logic                         o_err
);

  logic [1:0]        state_q [2];
  logic              wr_bank_q;
  logic              rd_bank_q;
  logic [NUM_RD-1:0] done_q;
  logic [NUM_RD-1:0] sel_q;

  logic              wr_acc;
  logic [NUM_RD-1:0] rd_acc;
  logic [NUM_RD-1:0] done_nxt;
  logic              release_bank;

  logic [1:0]                  bank_we;
  logic [NUM_RD-1:0]           bank_re [2];
  logic [NUM_RD*DATA_WIDTH-1:0] bank_rd [2];

  assign o_wr_ready = (state_q[wr_bank_q] == EMPTY) ||
                      (state_q[wr_bank_q] == FILLING);
  assign o_rd_ready = (state_q[rd_bank_q] == FULL);

  assign wr_acc   = i_wr_en && o_wr_ready;
  assign rd_acc   = i_rd_en & {NUM_RD{o_rd_ready}};
  assign done_nxt = done_q | (i_rd_done & {NUM_RD{o_rd_ready}});
  assign release_bank = o_rd_ready && (&done_nxt);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = wr_acc && (wr_bank_q == 1'(b));
    assign bank_re[b] = rd_acc & {NUM_RD{rd_bank_q == 1'(b)}};

    // Writer and readers never own the same bank, so at most
    // one of these branches is live for a given bank.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q[b] <= EMPTY;
      end else begin
        unique case (1'b1)
          release_bank && (rd_bank_q == 1'(b)):
            state_q[b] <= EMPTY;
          bank_we[b]:
            state_q[b] <= i_wr_last ? FULL : FILLING;
          default:
            state_q[b] <= state_q[b];
        endcase
      end
    end

    fmb_bank_1wnr #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .RAM_DEPTH (RAM_DEPTH),
      .NUM_RD    (NUM_RD)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (bank_we[b]),
      .wr_addr(i_wr_addr),
      .wr_data(i_wr_data),
      .rd_en  (bank_re[b]),
      .rd_addr(i_rd_addr),
      .rd_data(bank_rd[b])
    );
  end

  // Each port shows the bank it last read; both bank registers
  // hold when idle, so the output holds too.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    assign o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = sel_q[k] ?
      bank_rd[1][k*DATA_WIDTH +: DATA_WIDTH] :
      bank_rd[0][k*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      done_q     <= '0;
      sel_q      <= '0;
      o_rd_valid <= '0;
      o_err      <= 1'b0;
    end else begin
      o_rd_valid <= rd_acc;
      for (int k = 0; k < NUM_RD; k++) begin
        if (rd_acc[k]) sel_q[k] <= rd_bank_q;
      end
      if (wr_acc && i_wr_last) wr_bank_q <= ~wr_bank_q;
      if (release_bank) begin
        rd_bank_q <= ~rd_bank_q;
        done_q    <= '0;
      end else begin
        done_q <= done_nxt;
      end
      if ((i_wr_en && !o_wr_ready) ||
          (!o_rd_ready && ((|i_rd_en) || (|i_rd_done)))) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_feature_map_buffer_pingpong_1wnr.sv
// Directed self-checking bench for the ping-pong buffer.
// Drives inputs 1ns after each rising edge and checks there.
module tb_feature_map_buffer_pingpong_1wnr;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int NR = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_wr_en;
  logic [AW-1:0]  i_wr_addr;
  logic [DW-1:0]  i_wr_data;
  logic           i_wr_last;
  logic           o_wr_ready;
  logic [NR-1:0]  i_rd_en;
  logic [NR*AW-1:0] i_rd_addr;
  logic [NR*DW-1:0] o_rd_data;
  logic [NR-1:0]  o_rd_valid;
  logic [NR-1:0]  i_rd_done;
  logic           o_rd_ready;
  logic           o_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  feature_map_buffer_pingpong_1wnr #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_RD    (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_wr_last (i_wr_last),
    .o_wr_ready(o_wr_ready),
    .i_rd_en   (i_rd_en),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data),
    .o_rd_valid(o_rd_valid),
    .i_rd_done (i_rd_done),
    .o_rd_ready(o_rd_ready),
    .o_err     (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d,
                    input logic last);
    i_wr_en   = 1'b1;
    i_wr_addr = AW'(a);
    i_wr_data = d;
    i_wr_last = last;
    step();
    i_wr_en   = 1'b0;
    i_wr_last = 1'b0;
  endtask

  task automatic rd(input int a0, input int a1, input int a2,
                    input logic [2:0] en);
    i_rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
    i_rd_en   = en;
    step();
    i_rd_en   = '0;
  endtask

  task automatic done(input logic [2:0] d);
    i_rd_done = d;
    step();
    i_rd_done = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wr_ready"}, 32'(o_wr_ready), 32'd1);
    chk({tag, "_rd_ready"}, 32'(o_rd_ready), 32'd0);
    chk({tag, "_valid"},    32'(o_rd_valid), 32'd0);
    chk({tag, "_data"},     32'(o_rd_data),  32'd0);
    chk({tag, "_err"},      32'(o_err),      32'd0);
  endtask

  initial begin
    rst = 1'b1; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_wr_last = 1'b0; i_rd_en = '0; i_rd_addr = '0; i_rd_done = '0;
    step();
    step();
    rst = 1'b0;
    chk_reset_state("rst");

    // Frame 0 into bank 0: data = addr - 8
    for (int a = 0; a < 16; a++) wr(a, 8'(a - 8), a == 15);
    chk("f0_rd_ready", 32'(o_rd_ready), 32'd1);
    chk("f0_wr_ready", 32'(o_wr_ready), 32'd1);
    rd(15, 0, 7, 3'b111);
    chk("f0_valid", 32'(o_rd_valid), 32'h7);
    chk("f0_data",  32'(o_rd_data),  32'hFF_F8_07);
    step();
    chk("f0_valid_drop", 32'(o_rd_valid), 32'h0);
    chk("f0_data_hold",  32'(o_rd_data),  32'hFF_F8_07);

    // Frame 1 into bank 1 while readers hold bank 0
    for (int a = 0; a < 16; a++) wr(a, 8'(a + 100), a == 15);
    chk("ov_wr_full", 32'(o_wr_ready), 32'd0);
    done(3'b001);
    chk("ov_d0_rd_ready", 32'(o_rd_ready), 32'd1);
    chk("ov_d0_wr_ready", 32'(o_wr_ready), 32'd0);
    done(3'b100);
    chk("ov_d2_wr_ready", 32'(o_wr_ready), 32'd0);
    done(3'b010);
    chk("ov_rel_wr_ready", 32'(o_wr_ready), 32'd1);
    chk("ov_rel_rd_ready", 32'(o_rd_ready), 32'd1);
    rd(3, 4, 5, 3'b111);
    chk("ov_data", 32'(o_rd_data), 32'h69_68_67);
    chk("ov_err",  32'(o_err),     32'd0);

    // Backpressure: bank 0 filled again while bank 1 still read
    for (int a = 0; a < 4; a++) wr(a, 8'(a) ^ 8'h55, a == 3);
    chk("bp_wr_ready", 32'(o_wr_ready), 32'd0);
    wr(3, 8'h77, 1'b1);
    chk("bp_err", 32'(o_err), 32'd1);
    rd(3, 3, 0, 3'b011);
    chk("bp_b1_data", 32'(o_rd_data[15:0]), 32'h67_67);
    done(3'b111);
    chk("bp_rel_wr_ready", 32'(o_wr_ready), 32'd1);
    rd(3, 0, 1, 3'b111);
    chk("bp_b0_data", 32'(o_rd_data), 32'h54_55_56);

    // Release of bank 0 in the same cycle that bank 1 closes
    wr(0, 8'h20, 1'b0);
    i_rd_done = 3'b111;
    wr(1, 8'h21, 1'b1);
    i_rd_done = '0;
    chk("sim_rd_ready", 32'(o_rd_ready), 32'd1);
    chk("sim_wr_ready", 32'(o_wr_ready), 32'd1);
    rd(1, 0, 1, 3'b111);
    chk("sim_data", 32'(o_rd_data), 32'h21_20_21);
    chk("sim_err_sticky", 32'(o_err), 32'd1);

    // Idle read with both banks empty
    do_reset();
    chk("r2_err", 32'(o_err), 32'd0);
    for (int a = 0; a < 4; a++) wr(a, 8'(8'h10 + a), a == 3);
    rd(0, 1, 2, 3'b111);
    chk("id_data", 32'(o_rd_data), 32'h12_11_10);
    done(3'b111);
    chk("id_rd_ready", 32'(o_rd_ready), 32'd0);
    chk("id_err_pre", 32'(o_err), 32'd0);
    rd(3, 3, 3, 3'b101);
    chk("id_valid", 32'(o_rd_valid), 32'd0);
    chk("id_hold",  32'(o_rd_data),  32'h12_11_10);
    chk("id_err",   32'(o_err),      32'd1);

    // Reset in the middle of a frame
    for (int a = 0; a < 5; a++) wr(a, 8'(8'h30 + a), 1'b0);
    do_reset();
    chk_reset_state("mid");
    for (int a = 0; a < 8; a++) wr(a, 8'(8'hA0 + a), a == 7);
    chk("mid_rd_ready", 32'(o_rd_ready), 32'd1);
    rd(7, 0, 4, 3'b111);
    chk("mid_valid", 32'(o_rd_valid), 32'h7);
    chk("mid_data",  32'(o_rd_data),  32'hA4_A0_A7);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
